// File: rtl/rv32_isa_pkg.sv
// rtl/rv32_isa_pkg.sv - shared RV32/RV64 base ISA types, opcodes and the decoded-entry record
package rv32_isa_pkg;

  localparam int RegAddrWidth = 5;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } fmt_e;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  // PC and immediate are XLEN-wide, so they are queued alongside this record
  typedef struct packed {
    logic [6:0]              opcode;
    logic [2:0]              func3;
    logic [6:0]              func7;
    logic [RegAddrWidth-1:0] rs1;
    logic [RegAddrWidth-1:0] rs2;
    logic [RegAddrWidth-1:0] rd;
    fmt_e                    fmt;
    logic                    uses_rs1;
    logic                    uses_rs2;
    logic                    writes_rd;
    logic                    illegal;
  } dec_entry_t;

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational field, immediate and legality decoder for one instruction word
module decode_fields
  import rv32_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output dec_entry_t      entry,
  output logic [XLEN-1:0] imm
);

  localparam bit Rv64 = (XLEN == 64);

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  fmt_e               fmt;
  logic signed [31:0] imm32;
  logic               shift_bad;
  logic               ill;

  always_comb begin
    opcode = ins[6:0];
    f3     = ins[14:12];
    f7     = ins[31:25];

    case (opcode)
      OP:                                   fmt = FMT_R;
      OP_32:                                fmt = Rv64 ? FMT_R : FMT_NONE;
      OP_IMM, LOAD, JALR, MISC_MEM, SYSTEM: fmt = FMT_I;
      OP_IMM_32:                            fmt = Rv64 ? FMT_I : FMT_NONE;
      STORE:                                fmt = FMT_S;
      BRANCH:                               fmt = FMT_B;
      LUI, AUIPC:                           fmt = FMT_U;
      JAL:                                  fmt = FMT_J;
      default:                              fmt = FMT_NONE;
    endcase

    // Every immediate fits in 32 bits; the signed cast below widens it to XLEN
    case (fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'(imm32);

    // RV64 shift amounts are 6 bits, leaving a 6-bit upper field instead of 7
    shift_bad = 1'b0;
    if (f3 == 3'b001)
      shift_bad = Rv64 ? (ins[31:26] != 6'b000000) : (f7 != 7'b0000000);
    else if (f3 == 3'b101)
      shift_bad = Rv64 ? (ins[31:26] != 6'b000000 && ins[31:26] != 6'b010000)
                       : (f7 != 7'b0000000 && f7 != 7'b0100000);

    ill = (ins[1:0] != 2'b11) || (fmt == FMT_NONE);
    case (opcode)
      BRANCH: if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      JALR:   if (f3 != 3'b000) ill = 1'b1;
      LOAD:   if (f3 == 3'b111 || (!Rv64 && (f3 == 3'b011 || f3 == 3'b110))) ill = 1'b1;
      STORE:  if (f3 > (Rv64 ? 3'd3 : 3'd2)) ill = 1'b1;
      OP:     if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                ill = 1'b1;
      OP_IMM: if (shift_bad) ill = 1'b1;
      default: ;
    endcase

    entry.opcode    = opcode;
    entry.func3     = f3;
    entry.func7     = f7;
    entry.rs1       = ins[19:15];
    entry.rs2       = ins[24:20];
    entry.rd        = ins[11:7];
    entry.fmt       = fmt;
    entry.uses_rs1  = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B)
                      && !(opcode == SYSTEM && f3 == 3'b000);
    entry.uses_rs2  = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);
    entry.writes_rd = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
                      && (ins[11:7] != 5'd0) && !ill;
    entry.illegal   = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage: decoder feeding a DEPTH-entry in-order queue
module decode_stage
  import rv32_isa_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iFlush,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [31:0]             iINS,
  input  logic [XLEN-1:0]         iPC,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [XLEN-1:0]         oPC,
  output logic [6:0]              oOpCode,
  output logic [2:0]              oFunc3,
  output logic [6:0]              oFunc7,
  output logic [RegAddrWidth-1:0] oRS1,
  output logic [RegAddrWidth-1:0] oRS2,
  output logic [RegAddrWidth-1:0] oRD,
  output logic [XLEN-1:0]         oImm,
  output logic [2:0]              oFmt,
  output logic                    oUsesRS1,
  output logic                    oUsesRS2,
  output logic                    oWritesRD,
  output logic                    oIllegal
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  dec_entry_t      ent_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] imm_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] count_next;
  logic            push;
  logic            pop;

  dec_entry_t      dec;
  logic [XLEN-1:0] dec_imm;
  dec_entry_t      head;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .ins   (iINS),
    .entry (dec),
    .imm   (dec_imm)
  );

  assign push = iValid && oReady && !iFlush;
  assign pop  = oValid && iReady && !iFlush;

  always_comb begin
    count_next = count;
    if (iFlush)
      count_next = '0;
    else if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // Handshake flags are registered from the next count so they never see iValid/iReady
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      oReady <= 1'b1;
      oValid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_mem[i] <= '0;
        pc_mem[i]  <= '0;
        imm_mem[i] <= '0;
      end
    end else begin
      count  <= count_next;
      oReady <= (count_next != CntW'(DEPTH));
      oValid <= (count_next != '0);
      if (iFlush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          ent_mem[wr_ptr] <= dec;
          pc_mem[wr_ptr]  <= iPC;
          imm_mem[wr_ptr] <= dec_imm;
          wr_ptr          <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head      = ent_mem[rd_ptr];
  assign oPC       = pc_mem[rd_ptr];
  assign oImm      = imm_mem[rd_ptr];
  assign oOpCode   = head.opcode;
  assign oFunc3    = head.func3;
  assign oFunc7    = head.func7;
  assign oRS1      = head.rs1;
  assign oRS2      = head.rs2;
  assign oRD       = head.rd;
  assign oFmt      = head.fmt;
  assign oUsesRS1  = head.uses_rs1;
  assign oUsesRS2  = head.uses_rs2;
  assign oWritesRD = head.writes_rd;
  assign oIllegal  = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - checks 32- and 64-bit decode_stage instances against a queue-based reference model
module tb_decode_stage;
  import rv32_isa_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] ins = '0;
  logic [63:0] pc = '0;

  logic        r32, v32, u1_32, u2_32, wr32, ill32;
  logic [31:0] pc32, imm32;
  logic [6:0]  op32, f7_32;
  logic [2:0]  f3_32, fmt32;
  logic [4:0]  rs1_32, rs2_32, rd32;

  logic        r64, v64, u1_64, u2_64, wr64, ill64;
  logic [63:0] pc64, imm64;
  logic [6:0]  op64, f7_64;
  logic [2:0]  f3_64, fmt64;
  logic [4:0]  rs1_64, rs2_64, rd64;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .iClk(clk), .iRst_n(rst_n), .iFlush(flush), .iValid(valid), .oReady(r32),
    .iINS(ins), .iPC(pc[31:0]), .oValid(v32), .iReady(rdy), .oPC(pc32),
    .oOpCode(op32), .oFunc3(f3_32), .oFunc7(f7_32), .oRS1(rs1_32), .oRS2(rs2_32),
    .oRD(rd32), .oImm(imm32), .oFmt(fmt32), .oUsesRS1(u1_32), .oUsesRS2(u2_32),
    .oWritesRD(wr32), .oIllegal(ill32)
  );

  decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .iClk(clk), .iRst_n(rst_n), .iFlush(flush), .iValid(valid), .oReady(r64),
    .iINS(ins), .iPC(pc), .oValid(v64), .iReady(rdy), .oPC(pc64),
    .oOpCode(op64), .oFunc3(f3_64), .oFunc7(f7_64), .oRS1(rs1_64), .oRS2(rs2_64),
    .oRD(rd64), .oImm(imm64), .oFmt(fmt64), .oUsesRS1(u1_64), .oUsesRS2(u2_64),
    .oWritesRD(wr64), .oIllegal(ill64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode built from the encoding rules with integer arithmetic
  function automatic exp_t ref_dec(input int xlen, input logic [31:0] w, input logic [63:0] p);
    exp_t        e;
    int          s, lo, mid, hi, b;
    longint      v;
    logic [63:0] mask;
    logic        is_r, is_i;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    s = w;
    e = '0;
    e.pc  = p & mask;
    e.op  = w[6:0];
    e.f3  = w[14:12];
    e.f7  = w[31:25];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    case (e.op)
      7'h33:                             e.fmt = FMT_R;
      7'h3B:                             e.fmt = (xlen == 64) ? FMT_R : FMT_NONE;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: e.fmt = FMT_I;
      7'h1B:                             e.fmt = (xlen == 64) ? FMT_I : FMT_NONE;
      7'h23:                             e.fmt = FMT_S;
      7'h63:                             e.fmt = FMT_B;
      7'h37, 7'h17:                      e.fmt = FMT_U;
      7'h6F:                             e.fmt = FMT_J;
      default:                           e.fmt = FMT_NONE;
    endcase
    v = 0;
    case (e.fmt)
      FMT_I: v = s >>> 20;
      FMT_S: begin lo = w[11:7]; v = (s >>> 25) * 32 + lo; end
      FMT_B: begin
        b = w[7]; mid = w[30:25]; lo = w[11:8];
        v = (s >>> 31) * 4096 + b * 2048 + mid * 32 + lo * 2;
      end
      FMT_U: v = (s >>> 12) * 4096;
      FMT_J: begin
        hi = w[19:12]; b = w[20]; lo = w[30:21];
        v = (s >>> 31) * 1048576 + hi * 4096 + b * 2048 + lo * 2;
      end
      default: v = 0;
    endcase
    e.imm = 64'(v) & mask;
    e.ill = (w[1:0] != 2'b11) || (e.fmt == FMT_NONE);
    if (e.op == 7'h63 && (e.f3 == 2 || e.f3 == 3)) e.ill = 1;
    if (e.op == 7'h67 && e.f3 != 0) e.ill = 1;
    if (e.op == 7'h03 && (e.f3 == 7 || (xlen == 32 && (e.f3 == 3 || e.f3 == 6)))) e.ill = 1;
    if (e.op == 7'h23 && e.f3 > ((xlen == 32) ? 2 : 3)) e.ill = 1;
    if (e.op == 7'h33 && !(e.f7 == 0 || (e.f7 == 7'h20 && (e.f3 == 0 || e.f3 == 5)))) e.ill = 1;
    if (e.op == 7'h13 && e.f3 == 1) begin
      if (xlen == 32 ? (w[31:25] != 0) : (w[31:26] != 0)) e.ill = 1;
    end
    if (e.op == 7'h13 && e.f3 == 5) begin
      if (xlen == 32 ? !(w[31:25] == 7'h00 || w[31:25] == 7'h20)
                     : !(w[31:26] == 6'h00 || w[31:26] == 6'h10)) e.ill = 1;
    end
    is_r = (e.fmt == FMT_R);
    is_i = (e.fmt == FMT_I);
    e.u1 = (is_r || is_i || e.fmt == FMT_S || e.fmt == FMT_B) && !(e.op == 7'h73 && e.f3 == 0);
    e.u2 = is_r || e.fmt == FMT_S || e.fmt == FMT_B;
    e.wr = (is_r || is_i || e.fmt == FMT_U || e.fmt == FMT_J) && e.rd != 0 && !e.ill;
    return e;
  endfunction

  task automatic check_side(input string nm, input int sz, input exp_t h,
                            input logic v, input logic r, input logic [63:0] p,
                            input logic [63:0] im, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] ad, input logic [2:0] fm, input logic u1,
                            input logic u2, input logic wr, input logic il);
    check({nm, ".valid"}, v, sz > 0);
    check({nm, ".ready"}, r, sz < DEPTH);
    if (sz > 0) begin
      check({nm, ".pc"}, p, h.pc);
      check({nm, ".imm"}, im, h.imm);
      check({nm, ".op"}, op, h.op);
      check({nm, ".f3"}, f3, h.f3);
      check({nm, ".f7"}, f7, h.f7);
      check({nm, ".rs1"}, a1, h.rs1);
      check({nm, ".rs2"}, a2, h.rs2);
      check({nm, ".rd"}, ad, h.rd);
      check({nm, ".fmt"}, fm, h.fmt);
      check({nm, ".uses_rs1"}, u1, h.u1);
      check({nm, ".uses_rs2"}, u2, h.u2);
      check({nm, ".writes_rd"}, wr, h.wr);
      check({nm, ".illegal"}, il, h.ill);
    end
  endtask

  task automatic check_all();
    exp_t h32, h64;
    h32 = (q32.size() > 0) ? q32[0] : '0;
    h64 = (q64.size() > 0) ? q64[0] : '0;
    check_side("d32", q32.size(), h32, v32, r32, 64'(pc32), 64'(imm32), op32, f3_32, f7_32,
               rs1_32, rs2_32, rd32, fmt32, u1_32, u2_32, wr32, ill32);
    check_side("d64", q64.size(), h64, v64, r64, pc64, imm64, op64, f3_64, f7_64,
               rs1_64, rs2_64, rd64, fmt64, u1_64, u2_64, wr64, ill64);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare just after it
  task automatic step(input logic v, input logic [31:0] w, input logic [63:0] p,
                      input logic rd_in, input logic fl);
    bit full;
    valid = v; ins = w; pc = p; rdy = rd_in; flush = fl;
    @(posedge clk);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      full = (q32.size() >= DEPTH);
      if (q32.size() > 0 && rd_in) begin
        q32.delete(0);
        q64.delete(0);
      end
      if (v && !full) begin
        q32.push_back(ref_dec(32, w, p));
        q64.push_back(ref_dec(64, w, p));
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  ops [14];
    logic [31:0] w;
    int          k;
    ops = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h03, 7'h23, 7'h63,
            7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 14);
    if (k < 14) w[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
    if ($urandom_range(0, 2) == 0) w[14:12] = 3'd0;
    return w;
  endfunction

  task automatic check_zero_heads(input string nm);
    check({nm, ".v32"}, v32, 0);
    check({nm, ".r32"}, r32, 1);
    check({nm, ".v64"}, v64, 0);
    check({nm, ".r64"}, r64, 1);
    check({nm, ".pc32"}, pc32, 0);
    check({nm, ".imm32"}, imm32, 0);
    check({nm, ".op32"}, op32, 0);
    check({nm, ".rd32"}, rd32, 0);
    check({nm, ".fmt32"}, fmt32, 0);
    check({nm, ".ill32"}, ill32, 0);
    check({nm, ".pc64"}, pc64, 0);
    check({nm, ".imm64"}, imm64, 0);
    check({nm, ".f7_64"}, f7_64, 0);
    check({nm, ".rs1_64"}, rs1_64, 0);
    check({nm, ".wr64"}, wr64, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_heads("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 32'hFFF10093, 64'h1000, 0, 0);
    check("addi.valid", v32, 1);
    check("addi.op", op32, 7'h13);
    check("addi.rd", rd32, 1);
    check("addi.rs1", rs1_32, 2);
    check("addi.imm", imm32, 32'hFFFF_FFFF);
    check("addi.fmt", fmt32, FMT_I);
    check("addi.wr", wr32, 1);

    step(1, 32'hFE000EE3, 64'h1004, 1, 0);
    check("beq.imm", imm32, 32'hFFFF_FFFC);
    check("beq.fmt", fmt32, FMT_B);
    check("beq.rs2", u2_32, 1);
    check("beq.wr", wr32, 0);

    step(1, 32'hFE512C23, 64'h1008, 1, 0);
    check("sw.imm", imm32, 32'hFFFF_FFF8);
    check("sw.fmt", fmt32, FMT_S);
    step(1, 32'h123451B7, 64'h100C, 1, 0);
    check("lui.imm", imm32, 32'h1234_5000);
    check("lui.rd", rd32, 3);
    check("lui.fmt", fmt32, FMT_U);
    step(0, 32'h0, 64'h0, 1, 0);

    step(1, 32'h00100093, 64'h2000, 0, 0);
    step(1, 32'h00200113, 64'h2004, 0, 0);
    check("full.ready", r32, 0);
    step(1, 32'h00300193, 64'h2008, 0, 0);
    check("full.head_pc", pc32, 32'h2000);
    step(1, 32'h00300193, 64'h2008, 1, 0);
    step(1, 32'h00300193, 64'h2008, 1, 0);
    check("drain.pc", pc32, 32'h2008);
    step(0, 32'h0, 64'h0, 1, 0);

    step(1, 32'h0000_0000, 64'h3000, 0, 0);
    check("zero.ill", ill32, 1);
    check("zero.wr", wr32, 0);
    step(0, 32'h0, 64'h0, 1, 0);

    step(1, 32'h0000_001B, 64'h4000, 0, 0);
    check("addiw.ill64", ill64, 0);
    check("addiw.ill32", ill32, 1);
    step(1, 32'h00500293, 64'h4004, 0, 0);
    step(1, 32'h00600313, 64'h4008, 0, 1);
    check("flush.valid", v32, 0);
    check("flush.ready", r64, 1);
    step(0, 32'h0, 64'h0, 1, 0);

    step(1, 32'h00700393, 64'h5000, 0, 0);
    step(1, 32'h00800413, 64'h5004, 0, 0);
    rst_n = 1'b0;
    #1;
    q32.delete();
    q64.delete();
    check_zero_heads("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_ins(), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage. It takes fetched instruction words with their PCs over a valid/ready handshake and fully decodes each one: register fields, a single format-selected sign-extended immediate, the instruction format, register-usage flags and an illegal-instruction flag. Results are buffered in a DEPTH-entry in-order queue that feeds the execute stage over a second valid/ready handshake. The stage supports RV32I and, with XLEN=64, the RV64I base opcodes.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets immediate/PC width and enables RV64 opcodes.
- DEPTH, 2: queue entries, power of two, at least 2.
- iClk  in  1  clock; all state on rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iFlush  in  1  synchronous flush; empties the queue.
- iValid  in  1  upstream instruction valid.
- oReady  out  1  stage can accept this cycle.
- iINS  in  32  instruction word.
- iPC  in  XLEN  instruction PC.
- oValid  out  1  queue head valid.
- iReady  in  1  downstream accepts head.
- oPC  out  XLEN  head PC.
- oOpCode  out  7  head opcode.
- oFunc3  out  3  head function-3 field.
- oFunc7  out  7  head function-7 field.
- oRS1, oRS2, oRD  out  RegAddrWidth  head register addresses.
- oImm  out  XLEN  head immediate, sign/zero-extended per format.
- oFmt  out  3  head format, fmt_e.
- oUsesRS1, oUsesRS2, oWritesRD  out  1  head register-usage flags.
- oIllegal  out  1  head instruction is illegal.

## Operation
- Decode is combinational on iINS. The decoded entry is written into the queue on push (iValid && oReady && !iFlush).
- Immediates, extended to XLEN:
  - I: ins[31:20], sign-extended.
  - S: {ins[31:25], ins[11:7]}, sign-extended.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}, sign-extended.
  - U: {ins[31:12], 12'b0}, sign-extended to XLEN.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}, sign-extended.
  - R and NONE: 0.
- Format by opcode:
  - R: OP, and OP-32 when XLEN=64.
  - I: OP-IMM, LOAD, JALR, MISC-MEM, SYSTEM, and OP-IMM-32 when XLEN=64.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - Anything else: NONE.
- oUsesRS1 is set for R/I/S/B, except SYSTEM with func3=000.
- oUsesRS2 is set for R/S/B.
- oWritesRD is set for R/I/U/J when rd≠0, and is forced to 0 when illegal.
- oIllegal is set when any of the following holds:
  - ins[1:0]≠11.
  - Format is NONE.
  - BRANCH with func3 of 010 or 011.
  - JALR with func3≠000.
  - LOAD with func3 of 011 (XLEN=32), 110 (XLEN=32) or 111.
  - STORE with func3 above 010 (XLEN=32) or above 011 (XLEN=64).
  - OP with func7 not 0000000, or func7=0100000 with func3 other than 000 or 101.
  - OP-IMM shift with an illegal upper field.
- When an instruction is illegal, all fields are still decoded and presented.
- Queue behaviour:
  - oReady = !full.
  - oValid = !empty.
  - Pop on oValid && iReady.
  - Push and pop in the same cycle are allowed whenever not full; the count is unchanged.
  - There is no combinational input-to-output path.
- Boundary cases:
  - When full, oReady=0 and iValid is ignored.
  - iReady while empty has no effect.
  - Pointers wrap modulo DEPTH.
  - iFlush wins over push and pop in the same cycle: count and pointers go to 0 at the next edge, and the incoming word is dropped.

## Timing
- Latency is 1 cycle: an instruction pushed at edge N is visible with oValid=1 after edge N.
- Throughput is 1 instruction per cycle with iReady held high.
- oReady and oValid are registered; each depends only on the count.
- Reset asserted at any time, including mid-stream, immediately forces:
  - count and pointers to 0, so oValid=0 and oReady=1;
  - all payload storage to 0, so every head output reads 0.
- Upstream must hold iINS/iPC stable while iValid=1 and oReady=0. The stage requires this of upstream and does not check it.

## Structure
- Add to the shared rv32_isa package:
  - fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE};
  - opcode localparams (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM);
  - the dec_entry_t packed struct.
- One sub-module, decode_fields: the purely combinational XLEN-parametrised field/immediate/legality decoder.
- Queue storage and pointers live in decode_stage itself.

## Test plan
- XLEN=32, push 0xFFF10093 (addi x1,x2,-1) → next cycle: oValid=1, oOpCode=0x13, oRD=1, oRS1=2, oImm=0xFFFFFFFF, oFmt=FMT_I, oWritesRD=1.
- Push 0xFE000EE3 (beq x0,x0,-4) → oImm=0xFFFFFFFC, oFmt=FMT_B, oUsesRS2=1, oWritesRD=0.
- Push 0xFE512C23 (sw x5,-8(x2)), then 0x123451B7 (lui x3,0x12345) → oImm=0xFFFFFFF8 (FMT_S), then oImm=0x12345000 with oRD=3 (FMT_U).
- DEPTH=2, iReady=0, push 3 words → oReady=0 after the 2nd is accepted; the 3rd is held; after iReady=1 the words emerge in order, one per cycle.
- Push 0x00000000 → oIllegal=1, oWritesRD=0.
- XLEN=64, push 0x0000001B (OP-IMM-32) → legal.
- With 2 entries queued, assert iFlush together with iValid → oValid=0 next cycle and the new word is dropped.
- Assert iRst_n=0 mid-stream → immediate oValid=0, oReady=1, all head outputs 0.
